// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width and the responder FSM state encoding.
package spi_pkg;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_slv_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection on the synchronized value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, byte-wide rx/tx shift registers, one-entry tx holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy,
    output logic              o_tx_underrun,
    output logic              o_frame_err
);
    localparam int                CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic w_sclk_rise, w_sclk_fall, w_cs_q, w_cs_rise, w_cs_fall, w_mosi, w_wr;

    spi_slv_state_e    r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_sh, r_tx_sh, r_hold, r_rx_data;
    logic              r_full, r_rx_valid, r_underrun, r_frame_err;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
        .o_q(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // cs_n resets high so leaving reset never looks like a frame start
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
        .o_q(w_mosi), .o_rise(), .o_fall()
    );

    assign w_wr = i_tx_valid & ~r_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_wr) begin
                r_hold <= i_tx_data;
                r_full <= 1'b1;
            end
            if (w_cs_rise) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_tx_sh     <= '0;
                r_frame_err <= (r_cnt != '0);
            end else begin
                case (r_state)
                    IDLE: if (w_cs_fall) r_state <= LOAD;
                    // LOAD sees the registered holding state; a same-cycle write waits for the next word
                    LOAD: begin
                        r_tx_sh    <= r_full ? r_hold : '0;
                        r_underrun <= ~r_full;
                        if (r_full) r_full <= 1'b0;
                        r_state    <= SHIFT;
                    end
                    SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_mosi};
                            if (r_cnt == LAST) begin
                                r_rx_data  <= {r_rx_sh[DATA_W-2:0], w_mosi};
                                r_rx_valid <= 1'b1;
                                r_cnt      <= '0;
                                r_state    <= LOAD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (w_sclk_fall && r_cnt != '0) begin
                            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy        = ~w_cs_q;
    assign o_miso_oe     = ~w_cs_q;
    assign o_miso        = ~w_cs_q & r_tx_sh[DATA_W-1];
    assign o_tx_ready    = ~r_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;
    assign o_frame_err   = r_frame_err;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives frames and checks rx/tx data and status pulses.
module tb_spi_slave;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       tx_valid = 1'b0;

    int n_chk = 0, n_err = 0;
    int n_rxv = 0, n_ur = 0, n_fe = 0, ur_at_rxv = 0, n_idle_bad = 0;
    logic [7:0] rx_log [0:3];
    logic noise_on = 1'b0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy),
        .o_tx_underrun(tx_underrun), .o_frame_err(frame_err)
    );

    // pulse counters count high cycles, so a stretched pulse shows up as an extra count
    always @(posedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_log[n_rxv & 3] = rx_data;
                n_rxv     = n_rxv + 1;
                ur_at_rxv = n_ur;
            end
            if (tx_underrun) n_ur = n_ur + 1;
            if (frame_err)   n_fe = n_fe + 1;
            if (noise_on && (miso_oe || busy)) n_idle_bad = n_idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rxv = 0; n_ur = 0; n_fe = 0; ur_at_rxv = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // mode-0 master: mosi set while sclk low, miso sampled at the rising edge
    task automatic frame(input logic [15:0] data, input int nbits,
                         input logic mid_wr, input logic [7:0] mid_d, output logic [15:0] r);
        r = '0;
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(8);
        if (mid_wr) tx_write(mid_d);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            wait_clk(8);
            sclk = 1'b1;
            r = {r[14:0], miso};
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // single word; the trailing LOAD with an empty holding reg underruns after the word
        tx_write(8'h3C);
        check("t1_tx_ready_full", tx_ready, 0);
        clr();
        frame(16'h00A5, 8, 1'b0, 8'h00, rd);
        check("t1_miso_read", rd[7:0], 8'h3C);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_rxv_cnt", n_rxv, 1);
        check("t1_ur_before_rxv", ur_at_rxv, 0);
        check("t1_tx_ready", tx_ready, 1);
        check("t1_fe", n_fe, 0);

        // burst of two words, second tx byte written after the first LOAD
        tx_write(8'h11);
        clr();
        frame(16'h5AC3, 16, 1'b1, 8'h22, rd);
        check("t2_miso_read", rd, 16'h1122);
        check("t2_rxv_cnt", n_rxv, 2);
        check("t2_rx0", rx_log[0], 8'h5A);
        check("t2_rx1", rx_log[1], 8'hC3);
        check("t2_ur_before_last_rxv", ur_at_rxv, 0);
        check("t2_ur_total", n_ur, 1);
        check("t2_fe", n_fe, 0);

        // underrun: nothing loaded
        clr();
        frame(16'h00FF, 8, 1'b0, 8'h00, rd);
        check("t3_miso_read", rd[7:0], 8'h00);
        check("t3_rx_data", rx_data, 8'hFF);
        check("t3_ur_at_rxv", ur_at_rxv, 1);
        check("t3_ur_total", n_ur, 2);

        // abort after 5 bits of 0x96, then a clean 0x42 word
        clr();
        frame(16'h0012, 5, 1'b0, 8'h00, rd);
        check("t4_fe", n_fe, 1);
        check("t4_rxv_cnt", n_rxv, 0);
        check("t4_rx_data_kept", rx_data, 8'hFF);
        clr();
        frame(16'h0042, 8, 1'b0, 8'h00, rd);
        check("t4_rx_data", rx_data, 8'h42);
        check("t4_rxv_cnt2", n_rxv, 1);
        check("t4_fe2", n_fe, 0);

        // reset in the middle of a word
        tx_write(8'hE7);
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            wait_clk(8);
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check("t5_miso", miso, 0);
        check("t5_oe", miso_oe, 0);
        check("t5_busy", busy, 0);
        check("t5_tx_ready", tx_ready, 1);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_pulses", {rx_valid, tx_underrun, frame_err}, 3'b000);
        cs_n = 1'b1; mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        tx_write(8'h69);
        clr();
        frame(16'h0081, 8, 1'b0, 8'h00, rd);
        check("t5_miso_read", rd[7:0], 8'h69);
        check("t5_rx_data2", rx_data, 8'h81);
        check("t5_fe2", n_fe, 0);
        check("t5_ur_at_rxv", ur_at_rxv, 0);

        // idle noise with cs_n high
        tx_write(8'h55);
        clr();
        n_idle_bad = 0;
        noise_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mosi = i[0];
            wait_clk(5);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        wait_clk(5);
        noise_on = 1'b0;
        check("t6_rxv_cnt", n_rxv, 0);
        check("t6_oe_busy", n_idle_bad, 0);
        check("t6_tx_ready", tx_ready, 0);
        check("t6_miso", miso, 0);
        check("t6_pulses", n_ur + n_fe, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end
endmodule
